// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types, constants and state-matrix helpers.
// The standard word n sits at matrix[3-n/4][3-n%4].
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } pos_t;

    localparam word_t CHACHA_CONST [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FFWD,
        S_EMIT,
        S_NEXT
    } seq_state_e;

    function automatic pos_t word_pos(input logic [3:0] n);
        pos_t p;
        p.row = 2'd3 - n[3:2];
        p.col = 2'd3 - n[1:0];
        return p;
    endfunction

    function automatic matrix_t build_state(
        input logic [255:0] key,
        input logic [95:0]  nonce,
        input word_t        ctr
    );
        matrix_t m;
        pos_t    p;
        word_t   w;
        m = '0;
        for (int n = 0; n < 16; n++) begin
            if (n < 4)
                w = CHACHA_CONST[n];
            else if (n < 12)
                w = key[32*(n-4) +: 32];
            else if (n == 12)
                w = ctr;
            else
                w = nonce[32*(n-13) +: 32];
            p = word_pos(4'(n));
            m[p.row][p.col] = w;
        end
        return m;
    endfunction

endpackage

// File: rtl/chacha_block_sequencer.sv
// Sequences the external ChaCha20 round engine: load, run, feed-forward
// and stream 16 keystream words per block over valid/ready.
module chacha_block_sequencer
    import chacha_pkg::*;
#(
    parameter int NUM_BLOCKS  = 1,
    parameter int LOAD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [255:0]   key,
    input  logic [95:0]    nonce,
    input  logic [31:0]    init_counter,
    output logic           busy,
    output logic           setRounds,
    output matrix_t        chachamatrixIN,
    input  matrix_t        chachamatrixOUT,
    input  logic           blockready,
    output logic [31:0]    ks_word,
    output logic           ks_valid,
    input  logic           ks_ready,
    output logic           ks_last,
    output logic           ctr_wrap_err
);

    localparam pos_t CTR_POS = word_pos(4'd12);
    localparam pos_t W0_POS  = word_pos(4'd0);

    seq_state_e  state_q;
    matrix_t     matrix_q;
    matrix_t     sum_q;
    matrix_t     sum_d;
    logic [3:0]  idx_q;
    logic [7:0]  blk_q;
    logic [15:0] load_cnt_q;
    logic        br_q;
    logic        busy_q;
    logic        set_rounds_q;
    word_t       ks_word_q;
    logic        ks_valid_q;
    logic        ks_last_q;
    logic        err_q;
    pos_t        nxt_pos;
    word_t       nxt_word;
    logic        last_blk;

    assign busy           = busy_q;
    assign setRounds      = set_rounds_q;
    assign chachamatrixIN = matrix_q;
    assign ks_word        = ks_word_q;
    assign ks_valid       = ks_valid_q;
    assign ks_last        = ks_last_q;
    assign ctr_wrap_err   = err_q;

    assign last_blk = (blk_q == 8'(NUM_BLOCKS - 1));

    always_comb begin
        sum_d = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum_d[r][c] = chachamatrixOUT[r][c] + matrix_q[r][c];
            end
        end
        nxt_pos  = word_pos(idx_q + 4'd1);
        nxt_word = sum_q[nxt_pos.row][nxt_pos.col];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            matrix_q     <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            blk_q        <= '0;
            load_cnt_q   <= '0;
            br_q         <= 1'b0;
            busy_q       <= 1'b0;
            set_rounds_q <= 1'b1;
            ks_word_q    <= '0;
            ks_valid_q   <= 1'b0;
            ks_last_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            br_q <= blockready;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        matrix_q     <= build_state(key, nonce, init_counter);
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        set_rounds_q <= 1'b1;
                        blk_q        <= '0;
                        load_cnt_q   <= '0;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_cnt_q == 16'(LOAD_CYCLES - 1)) begin
                        set_rounds_q <= 1'b0;
                        state_q      <= S_RUN;
                    end else begin
                        load_cnt_q <= load_cnt_q + 16'd1;
                    end
                end
                S_RUN: begin
                    // Only a fresh 0->1 transition marks a finished block.
                    if (blockready && !br_q) begin
                        set_rounds_q <= 1'b1;
                        state_q      <= S_FFWD;
                    end
                end
                S_FFWD: begin
                    sum_q      <= sum_d;
                    ks_word_q  <= sum_d[W0_POS.row][W0_POS.col];
                    ks_valid_q <= 1'b1;
                    ks_last_q  <= 1'b0;
                    idx_q      <= '0;
                    state_q    <= S_EMIT;
                end
                S_EMIT: begin
                    if (ks_ready) begin
                        if (idx_q != 4'd15) begin
                            idx_q     <= idx_q + 4'd1;
                            ks_word_q <= nxt_word;
                            ks_last_q <= (idx_q == 4'd14) && last_blk;
                        end else begin
                            ks_valid_q <= 1'b0;
                            ks_last_q  <= 1'b0;
                            blk_q      <= blk_q + 8'd1;
                            if (last_blk) begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else if (&matrix_q[CTR_POS.row][CTR_POS.col]) begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    end
                end
                S_NEXT: begin
                    matrix_q[CTR_POS.row][CTR_POS.col] <=
                        matrix_q[CTR_POS.row][CTR_POS.col] + 32'd1;
                    load_cnt_q <= '0;
                    state_q    <= S_LOAD;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Self-checking bench: behavioural ChaCha20 engine plus block-level reference model.
// Two DUT instances cover NUM_BLOCKS=1 and NUM_BLOCKS=2.
module tb_chacha_block_sequencer;
    import chacha_pkg::*;

    typedef word_t [15:0] st_t;

    typedef struct {
        logic [255:0]  key;
        logic [95:0]   nonce;
        word_t         ctr;
        int            sel;
        bit            rnd;
        int            nwords;
        bit            exp_err;
        word_t [0:31]  exp;
    } vec_t;

    localparam logic [255:0] RFC_KEY =
        256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [95:0] RFC_NONCE = 96'h00000000_4a000000_09000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ks_ready = 1'b1;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    word_t        init_counter = '0;

    int   sel = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_fix = 1'b1;
    int   eng_delay = 2;
    logic br_force = 1'b0;
    logic br_force_val = 1'b0;

    logic    sr_a [2];
    logic    busy_a [2];
    logic    kv_a [2];
    logic    kl_a [2];
    logic    err_a [2];
    word_t   kw_a [2];
    matrix_t mi_a [2];

    logic    sr_s, busy_s, kv_s, kl_s, err_s;
    word_t   kw_s;
    matrix_t mi_s;

    assign sr_s   = sr_a[sel];
    assign busy_s = busy_a[sel];
    assign kv_s   = kv_a[sel];
    assign kl_s   = kl_a[sel];
    assign err_s  = err_a[sel];
    assign kw_s   = kw_a[sel];
    assign mi_s   = mi_a[sel];

    int    n_cmp = 0;
    int    n_fail = 0;
    word_t got_w [$];
    logic  got_l [$];
    bit    stall_prev = 1'b0;
    word_t stall_word = '0;
    word_t ctr_seen = '0;
    word_t rfc_exp [16];
    vec_t  vt [6];

    // ---------------- reference model ----------------
    function automatic word_t rotl(input word_t v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic st_t qr(input st_t s, input int a, b, c, d);
        s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16);
        s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8);
        s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7);
        return s;
    endfunction

    function automatic st_t perm_std(input st_t s);
        for (int i = 0; i < 10; i++) begin
            s = qr(s, 0, 4, 8, 12);
            s = qr(s, 1, 5, 9, 13);
            s = qr(s, 2, 6, 10, 14);
            s = qr(s, 3, 7, 11, 15);
            s = qr(s, 0, 5, 10, 15);
            s = qr(s, 1, 6, 11, 12);
            s = qr(s, 2, 7, 8, 13);
            s = qr(s, 3, 4, 9, 14);
        end
        return s;
    endfunction

    function automatic st_t std_init(input logic [255:0] k, input logic [95:0] n, input word_t c);
        st_t s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        return s;
    endfunction

    function automatic st_t ref_block(input logic [255:0] k, input logic [95:0] n, input word_t c);
        st_t x, y;
        x = std_init(k, n, c);
        y = perm_std(x);
        for (int i = 0; i < 16; i++) y[i] = y[i] + x[i];
        return y;
    endfunction

    function automatic st_t m2s(input matrix_t m);
        st_t s;
        for (int n = 0; n < 16; n++) s[n] = m[3 - n/4][3 - n%4];
        return s;
    endfunction

    function automatic matrix_t s2m(input st_t s);
        matrix_t m;
        for (int n = 0; n < 16; n++) m[3 - n/4][3 - n%4] = s[n];
        return m;
    endfunction

    function automatic logic [255:0] rkey();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic vec_t mk(input logic [255:0] k, input logic [95:0] n, input word_t c,
                                input int s, input bit r, input int nb, input bit e);
        vec_t v;
        st_t  b;
        v.key = k; v.nonce = n; v.ctr = c; v.sel = s; v.rnd = r;
        v.exp_err = e;
        v.nwords = e ? 16 : 16 * nb;
        v.exp = '0;
        for (int j = 0; j < nb; j++) begin
            b = ref_block(k, n, c + 32'(j));
            for (int i = 0; i < 16; i++) v.exp[16*j + i] = b[i];
        end
        return v;
    endfunction

    // ---------------- DUTs and engine models ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic    sr, busy, kv, kl, err, br;
        logic    be = 1'b0;
        int      cnt_e = 0;
        word_t   kw;
        matrix_t mi;
        matrix_t mo = '0;

        chacha_block_sequencer #(
            .NUM_BLOCKS (g + 1),
            .LOAD_CYCLES(2)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .key            (key),
            .nonce          (nonce),
            .init_counter   (init_counter),
            .busy           (busy),
            .setRounds      (sr),
            .chachamatrixIN (mi),
            .chachamatrixOUT(mo),
            .blockready     (br),
            .ks_word        (kw),
            .ks_valid       (kv),
            .ks_ready       (ks_ready),
            .ks_last        (kl),
            .ctr_wrap_err   (err)
        );

        assign br = br_force ? br_force_val : be;

        // Engine: runs while setRounds=0, then holds its result and raises blockready.
        always @(posedge clk) begin
            if (sr) begin
                cnt_e <= 0;
                be    <= 1'b0;
            end else if (!be) begin
                if (cnt_e >= eng_delay) begin
                    mo <= s2m(perm_std(m2s(mi)));
                    be <= 1'b1;
                end else begin
                    cnt_e <= cnt_e + 1;
                end
            end
        end

        assign sr_a[g]   = sr;
        assign busy_a[g] = busy;
        assign kv_a[g]   = kv;
        assign kl_a[g]   = kl;
        assign err_a[g]  = err;
        assign kw_a[g]   = kw;
        assign mi_a[g]   = mi;
    end

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        ks_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    // Handshake capture and stall-stability check on the selected instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                n_cmp++;
                if (!(kv_s && kw_s == stall_word)) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b word=%h required valid=1 word=%h",
                             kv_s, kw_s, stall_word);
                end
            end
            if (kv_s && ks_ready) begin
                got_w.push_back(kw_s);
                got_l.push_back(kl_s);
            end
            if (busy_s && sr_s) ctr_seen = mi_s[0][3];
            stall_prev = kv_s && !ks_ready;
            stall_word = kw_s;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br_force = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic setup(input vec_t v);
        sel = v.sel;
        key = v.key;
        nonce = v.nonce;
        init_counter = v.ctr;
        rdy_rand = v.rnd;
        rdy_fix = 1'b1;
        eng_delay = $urandom_range(0, 6);
    endtask

    task automatic collect(input vec_t v, input string tag);
        int t = 0;
        while (got_w.size() < v.nwords && t < 4000) begin
            tick();
            t++;
        end
        repeat (40) tick();
        chkw({tag, "_nwords"}, 32'(got_w.size()), 32'(v.nwords));
        for (int i = 0; i < v.nwords && i < got_w.size(); i++) begin
            chkw($sformatf("%s_word%0d", tag, i), got_w[i], v.exp[i]);
            chk1($sformatf("%s_last%0d", tag, i), got_l[i],
                 !v.exp_err && (i == v.nwords - 1));
        end
        chk1({tag, "_busy_end"}, busy_s, 1'b0);
        chk1({tag, "_err"}, err_s, v.exp_err);
        if (v.nwords == 32)
            chkw({tag, "_ctr2"}, ctr_seen, v.ctr + 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        sel = v.sel;
        do_reset();
        setup(v);
        got_w.delete();
        got_l.delete();
        pulse_start();
        collect(v, tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t v;
        bit   saw;
        int   t;

        rfc_exp = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

        vt[0] = mk(RFC_KEY, RFC_NONCE, 32'd1, 0, 1'b0, 1, 1'b0);
        vt[1] = mk(RFC_KEY, RFC_NONCE, 32'd1, 0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            vt[0].exp[i] = rfc_exp[i];
            vt[1].exp[i] = rfc_exp[i];
        end
        vt[2] = mk(rkey(), {$urandom, $urandom, $urandom}, $urandom, 0, 1'b1, 1, 1'b0);
        vt[3] = mk(rkey(), {$urandom, $urandom, $urandom}, 32'd1, 1, 1'b1, 2, 1'b0);
        vt[4] = mk(rkey(), {$urandom, $urandom, $urandom}, 32'hFFFFFFFF, 1, 1'b0, 2, 1'b1);
        vt[5] = mk(rkey(), {$urandom, $urandom, $urandom},
                   $urandom_range(0, 32'hFFFFFFFE), 1, 1'b1, 2, 1'b0);

        // Reset state
        tick();
        tick();
        chk1("rst_setRounds", sr_s, 1'b1);
        chk1("rst_busy", busy_s, 1'b0);
        chk1("rst_valid", kv_s, 1'b0);
        chk1("rst_last", kl_s, 1'b0);
        chk1("rst_err", err_s, 1'b0);
        chk1("rst_matrix_zero", mi_s == '0, 1'b1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Wrap error clears on the next accepted start
        run_vec(vt[4], "wrap_again");
        init_counter = 32'd5;
        pulse_start();
        chk1("err_cleared", err_s, 1'b0);
        chk1("restart_busy", busy_s, 1'b1);

        // Reset while word 7 is stalled
        v = vt[0];
        sel = 0;
        do_reset();
        setup(v);
        got_w.delete();
        got_l.delete();
        pulse_start();
        t = 0;
        while (got_w.size() < 6 && t < 2000) begin
            tick();
            t++;
        end
        rdy_fix = 1'b0;
        tick();
        tick();
        chk1("w7_valid", kv_s, 1'b1);
        chkw("w7_word", kw_s, rfc_exp[7]);
        rst_n = 1'b0;
        tick();
        chk1("midrst_valid", kv_s, 1'b0);
        chk1("midrst_setRounds", sr_s, 1'b1);
        chk1("midrst_busy", busy_s, 1'b0);
        chkw("midrst_count", 32'(got_w.size()), 32'd7);
        rst_n = 1'b1;
        rdy_fix = 1'b1;
        tick();
        got_w.delete();
        got_l.delete();
        pulse_start();
        collect(v, "after_rst");

        // blockready already high entering RUN; start while busy is ignored
        sel = 0;
        do_reset();
        setup(v);
        eng_delay = 1;
        br_force = 1'b1;
        br_force_val = 1'b1;
        got_w.delete();
        got_l.delete();
        pulse_start();
        t = 0;
        while (sr_s && t < 100) begin
            tick();
            t++;
        end
        chk1("enter_run", sr_s, 1'b0);
        saw = 1'b0;
        repeat (5) begin
            tick();
            saw |= kv_s;
        end
        key = rkey();
        init_counter = $urandom;
        pulse_start();
        repeat (6) begin
            tick();
            saw |= kv_s;
        end
        key = RFC_KEY;
        chk1("no_ffwd_while_high", saw, 1'b0);
        chk1("busy_held", busy_s, 1'b1);
        br_force_val = 1'b0;
        tick();
        tick();
        br_force = 1'b0;
        tick();
        chk1("lat_cycle1", kv_s, 1'b0);
        tick();
        chk1("lat_cycle2", kv_s, 1'b1);
        chkw("lat_word0", kw_s, rfc_exp[0]);
        collect(v, "held_high");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
